uart_rx_frontend: RTL and testbench

Oversampling serial receiver that turns the raw asynchronous RxD pin into a byte stream with per-byte framing status. It sits directly upstream of the AXI-lite UART core's receive FIFO and replaces its single-sample bit capture. It adds metastability protection, majority-vote sampling, false-start rejection, framing/overrun flags and optional break detection.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_baud_tick.sv | 36 +++
 rtl/uart_rx_frontend.sv | 199 +++++++++++++++++++
 tb/tb_uart_rx_frontend.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampling UART receiver front end.
package uart_pkg;

    localparam int OVERSAMPLE = 16;

    localparam logic [3:0] SAMPLE_LO  = 4'd7;
    localparam logic [3:0] SAMPLE_MID = 4'd8;
    localparam logic [3:0] SAMPLE_HI  = 4'd9;
    localparam logic [3:0] SUB_LAST   = 4'd15;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider that emits a one-clock tick every DIV clocks.
module uart_baud_tick #(
    parameter int DIV = 54
) (
    input  logic clock,
    input  logic reset,
    output logic tick_o
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    if (DIV < 2) begin : g_bad_div
        $error("uart_baud_tick: DIV must be at least 2");
    end

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_frontend.sv
// Oversampling UART receiver: synchronizer, 3-sample majority vote, framing/overrun flags.
// Optional break detection when UART_RX_BREAK_EN is defined.
module uart_rx_frontend #(
    parameter int CLOCK_HZ   = 100_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rxd,
    output logic       m_valid,
    input  logic       m_ready,
    output logic [7:0] m_data,
    output logic       m_ferr,
`ifdef UART_RX_BREAK_EN
    output logic       m_break,
`endif
    output logic       overrun
);

    import uart_pkg::*;

    localparam int DIV = CLOCK_HZ / (BAUD_RATE * OVERSAMPLE);

    if (OVERSAMPLE != uart_pkg::OVERSAMPLE) begin : g_bad_os
        $error("uart_rx_frontend: only 16x oversampling is supported");
    end

    logic tick;

    uart_baud_tick #(
        .DIV (DIV)
    ) u_tick (
        .clock  (clock),
        .reset  (reset),
        .tick_o (tick)
    );

    logic rxd_meta_q, rxd_sync_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
        end else begin
            rxd_meta_q <= rxd;
            rxd_sync_q <= rxd_meta_q;
        end
    end

    rx_state_t   state_q, state_d;
    logic [3:0]  sub_q, sub_d;
    logic [3:0]  sub_n;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        samp_a_q, samp_a_d;
    logic        samp_b_q, samp_b_d;
    logic        maj;
    logic        deliver;
    logic        del_ferr;
    logic        del_brk;

    // sub_q holds the sub-bit index of the most recent tick; sub_n is the index of this tick
    assign sub_n = sub_q + 4'd1;
    assign maj   = majority3(samp_a_q, samp_b_q, rxd_sync_q);

    always_comb begin
        state_d  = state_q;
        sub_d    = sub_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        samp_a_d = samp_a_q;
        samp_b_d = samp_b_q;
        deliver  = 1'b0;
        del_ferr = 1'b0;
        del_brk  = 1'b0;

        if (tick) begin
            if (state_q == START || state_q == DATA || state_q == STOP) begin
                sub_d = sub_n;
                if (sub_n == SAMPLE_LO) samp_a_d = rxd_sync_q;
                if (sub_n == SAMPLE_MID) samp_b_d = rxd_sync_q;
            end

            case (state_q)
                IDLE: begin
                    if (!rxd_sync_q) begin
                        state_d = START;
                        sub_d   = 4'd0;
                    end
                end
                START: begin
                    if (sub_n == SAMPLE_HI && maj) begin
                        state_d = IDLE;
                    end else if (sub_n == SUB_LAST) begin
                        state_d = DATA;
                        bit_d   = 3'd0;
                    end
                end
                DATA: begin
                    if (sub_n == SAMPLE_HI) begin
                        shift_d = {maj, shift_q[7:1]};
                    end
                    if (sub_n == SUB_LAST) begin
                        if (bit_q == 3'd7) begin
                            state_d = STOP;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end
                end
                STOP: begin
                    // Leave at mid-stop so the next falling edge can resync immediately
                    if (sub_n == SAMPLE_HI) begin
                        deliver  = 1'b1;
                        del_ferr = !maj;
                        state_d  = IDLE;
`ifdef UART_RX_BREAK_EN
                        if (shift_q == 8'h00 && !maj) begin
                            del_brk = 1'b1;
                            state_d = BREAK;
                        end
`endif
                    end
                end
`ifdef UART_RX_BREAK_EN
                BREAK: begin
                    if (rxd_sync_q) begin
                        state_d = IDLE;
                    end
                end
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            sub_q   <= 4'd0;
            bit_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            sub_q   <= sub_d;
            bit_q   <= bit_d;
        end
    end

    always_ff @(posedge clock) begin
        shift_q  <= shift_d;
        samp_a_q <= samp_a_d;
        samp_b_q <= samp_b_d;
    end

    logic       m_valid_q;
    logic [7:0] m_data_q;
    logic       m_ferr_q;
    logic       m_break_q;
    logic       overrun_q;
    logic       drop;
    logic       load;

    // A pending byte accepted this cycle frees the slot for a same-cycle delivery
    assign drop = deliver && m_valid_q && !m_ready;
    assign load = deliver && !drop;

    always_ff @(posedge clock) begin
        if (reset) begin
            m_valid_q <= 1'b0;
            m_data_q  <= 8'h00;
            m_ferr_q  <= 1'b0;
            m_break_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= drop;
            if (load) begin
                m_valid_q <= 1'b1;
                m_data_q  <= shift_q;
                m_ferr_q  <= del_ferr;
                m_break_q <= del_brk;
            end else if (m_ready) begin
                m_valid_q <= 1'b0;
            end
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_ferr  = m_ferr_q;
    assign overrun = overrun_q;
`ifdef UART_RX_BREAK_EN
    assign m_break = m_break_q;
`else
    logic unused_break;
    assign unused_break = m_break_q;
`endif

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Directed bench for uart_rx_frontend at default rates (DIV=54, 864 clocks per bit).
module tb_uart_rx_frontend;

    localparam int BIT = 864;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       rxd = 1'b1;
    logic       m_ready = 1'b1;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_ferr;
    logic       overrun;
    logic       brk_obs;
`ifdef UART_RX_BREAK_EN
    logic       m_break;
    assign brk_obs = m_break;
`else
    assign brk_obs = 1'b0;
`endif

    uart_rx_frontend dut (
        .clock   (clock),
        .reset   (reset),
        .rxd     (rxd),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_ferr  (m_ferr),
`ifdef UART_RX_BREAK_EN
        .m_break (m_break),
`endif
        .overrun (overrun)
    );

    always #5 clock = ~clock;

    int         n_rx = 0;
    int         n_vcyc = 0;
    int         n_ovr = 0;
    int         n_zf = 0;
    logic [7:0] cap_data [64];
    logic       cap_ferr [64];
    logic       cap_brk  [64];

    // Handshakes and pulses are observed mid-cycle, away from the active edge
    always @(negedge clock) begin
        if (m_valid) n_vcyc <= n_vcyc + 1;
        if (overrun) n_ovr <= n_ovr + 1;
        if (m_valid && m_ready) begin
            cap_data[n_rx[5:0]] <= m_data;
            cap_ferr[n_rx[5:0]] <= m_ferr;
            cap_brk[n_rx[5:0]]  <= brk_obs;
            n_rx <= n_rx + 1;
            if (m_data == 8'h00 && m_ferr) n_zf <= n_zf + 1;
        end
    end

    int nvec = 0;
    int nfail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clocks(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rxd = 1'b0;
        clocks(BIT);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            clocks(BIT);
        end
        rxd = stop_bit;
        clocks(BIT);
        rxd = 1'b1;
    endtask

    int r0, v0, o0, z0;

    initial begin
        clocks(5);
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_m_data", {24'd0, m_data}, 32'h00);
        check("rst_m_ferr", {31'd0, m_ferr}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        check("rst_m_break", {31'd0, brk_obs}, 32'd0);
        reset = 1'b0;
        clocks(BIT);

        r0 = n_rx; v0 = n_vcyc; o0 = n_ovr;
        send_frame(8'h55, 1'b1);
        clocks(20);
        check("f55_count", n_rx - r0, 1);
        check("f55_data", {24'd0, cap_data[r0[5:0]]}, 32'h55);
        check("f55_ferr", {31'd0, cap_ferr[r0[5:0]]}, 32'd0);
        check("f55_vcycles", n_vcyc - v0, 1);
        check("f55_overrun", n_ovr - o0, 0);

        r0 = n_rx;
        rxd = 1'b0;
        clocks(162);
        rxd = 1'b1;
        clocks(BIT);
        check("glitch_none", n_rx - r0, 0);
        send_frame(8'h3C, 1'b1);
        clocks(20);
        check("f3c_count", n_rx - r0, 1);
        check("f3c_data", {24'd0, cap_data[r0[5:0]]}, 32'h3C);
        check("f3c_ferr", {31'd0, cap_ferr[r0[5:0]]}, 32'd0);

        r0 = n_rx;
        send_frame(8'hA3, 1'b0);
        clocks(BIT);
        check("fa3_count", n_rx - r0, 1);
        check("fa3_data", {24'd0, cap_data[r0[5:0]]}, 32'hA3);
        check("fa3_ferr", {31'd0, cap_ferr[r0[5:0]]}, 32'd1);

        r0 = n_rx; o0 = n_ovr;
        m_ready = 1'b0;
        send_frame(8'h12, 1'b1);
        clocks(20);
        send_frame(8'h34, 1'b1);
        clocks(20);
        check("ovr_pulses", n_ovr - o0, 1);
        check("ovr_held_valid", {31'd0, m_valid}, 32'd1);
        check("ovr_held_data", {24'd0, m_data}, 32'h12);
        check("ovr_held_ferr", {31'd0, m_ferr}, 32'd0);
        check("ovr_no_accept", n_rx - r0, 0);
        m_ready = 1'b1;
        clocks(4);
        check("ovr_accept_count", n_rx - r0, 1);
        check("ovr_accept_data", {24'd0, cap_data[r0[5:0]]}, 32'h12);
        check("ovr_valid_clear", {31'd0, m_valid}, 32'd0);

        r0 = n_rx; z0 = n_zf;
        rxd = 1'b0;
        clocks(20 * BIT);
        rxd = 1'b1;
        clocks(BIT);
`ifdef UART_RX_BREAK_EN
        check("brk_count", n_rx - r0, 1);
        check("brk_data", {24'd0, cap_data[r0[5:0]]}, 32'h00);
        check("brk_ferr", {31'd0, cap_ferr[r0[5:0]]}, 32'd1);
        check("brk_flag", {31'd0, cap_brk[r0[5:0]]}, 32'd1);
`else
        check("lowline_zero_ferr", n_zf - z0, 2);
        check("lowline_brk_flag", {31'd0, cap_brk[r0[5:0]]}, 32'd0);
`endif

        // Start a 0xFF frame and reset after its data bit 3; the rest of the line stays high
        rxd = 1'b0;
        clocks(BIT);
        rxd = 1'b1;
        clocks(4 * BIT);
        reset = 1'b1;
        clocks(3);
        reset = 1'b0;
        r0 = n_rx;
        clocks(6 * BIT);
        check("midrst_valid", {31'd0, m_valid}, 32'd0);
        check("midrst_none", n_rx - r0, 0);
        send_frame(8'h7E, 1'b1);
        clocks(20);
        check("f7e_count", n_rx - r0, 1);
        check("f7e_data", {24'd0, cap_data[r0[5:0]]}, 32'h7E);
        check("f7e_ferr", {31'd0, cap_ferr[r0[5:0]]}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
